sb_cfg_loader: RTL and testbench

//  Configuration controller for an array of fullSB switchboxes. Accepts one 9-bit

---
 rtl/sb_cfg_loader.sv | 116 +++++++++++
 tb/tb_sb_cfg_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_loader.sv
// Loads one config word per fullSB switchbox into shadow registers, validates each word,
// and commits the whole set to the active config bus in one step, or not at all.
module sb_cfg_loader #(
    parameter  int NUM_SB  = 4,
    parameter  int CFG_W   = 9,
    parameter  int MAX_DRV = 2,
    localparam int IDX_W   = $clog2(NUM_SB)
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cfg_valid,
    input  logic [CFG_W-1:0]        cfg_word,
    output logic                    cfg_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [IDX_W-1:0]        err_idx,
    output logic [NUM_SB*CFG_W-1:0] active_cfg
);

    localparam int NUM_FIELDS = (CFG_W - 1) / 2;
    localparam int CNT_W      = $clog2(NUM_FIELDS + 1) + 1;
    localparam logic [CNT_W-1:0] MAX_DRV_C = CNT_W'(MAX_DRV);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SB - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, ERROR} state_t;

    state_t           state;
    logic [CFG_W-1:0] shadow [NUM_SB];
    logic [IDX_W-1:0] idx;
    logic             err_flag;
    logic             commit_pending;
    logic [CNT_W-1:0] drv_cnt;
    logic             bad_field;
    logic             word_illegal;

    // Legality of the word currently offered on the stream.
    always_comb begin
        drv_cnt   = '0;
        bad_field = 1'b0;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (cfg_word[2*f +: 2] == 2'b11) bad_field = 1'b1;
            if (cfg_word[2*f +: 2] == 2'b10) drv_cnt = drv_cnt + CNT_W'(1);
        end
        word_illegal = bad_field || (drv_cnt > MAX_DRV_C);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            idx            <= '0;
            err_flag       <= 1'b0;
            commit_pending <= 1'b0;
            err_idx        <= '0;
            active_cfg     <= '0;
            cfg_ready      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            for (int i = 0; i < NUM_SB; i++) shadow[i] <= '0;
        end else begin
            done <= 1'b0;
            // The commit is registered one edge after CHECK so active_cfg and done move together.
            if (commit_pending) begin
                for (int i = 0; i < NUM_SB; i++) active_cfg[i*CFG_W +: CFG_W] <= shadow[i];
                done           <= 1'b1;
                commit_pending <= 1'b0;
            end
            case (state)
                IDLE, ERROR: begin
                    if (start) begin
                        state     <= LOAD;
                        idx       <= '0;
                        err_flag  <= 1'b0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cfg_valid) begin
                        shadow[idx] <= cfg_word;
                        if (word_illegal && !err_flag) begin
                            err_flag <= 1'b1;
                            err_idx  <= idx;
                        end
                        if (idx == LAST_IDX) begin
                            state     <= CHECK;
                            cfg_ready <= 1'b0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                CHECK: begin
                    busy <= 1'b0;
                    if (err_flag) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else begin
                        state          <= IDLE;
                        commit_pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Randomized self-checking bench for sb_cfg_loader against a transaction-level model
// of which words end up on the active config bus.
module tb_sb_cfg_loader;

    localparam int N = 4;
    localparam int W = 9;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           nrst;
    logic           start, abort, cfg_valid;
    logic [W-1:0]   cfg_word;
    logic           cfg_ready, busy, done, error;
    logic [IW-1:0]  err_idx;
    logic [N*W-1:0] active_cfg;

    logic [W-1:0]   model_active [N];
    int             checks = 0;
    int             errors = 0;

    sb_cfg_loader #(.NUM_SB(N), .CFG_W(W), .MAX_DRV(2)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_word(cfg_word), .cfg_ready(cfg_ready),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx),
        .active_cfg(active_cfg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Word legality from the field rules: no 11 field, at most two drive fields.
    function automatic bit word_ok(input logic [W-1:0] w);
        int drv = 0;
        int v;
        for (int f = 0; f < 4; f++) begin
            v = int'((w >> (2*f)) & 9'd3);
            if (v == 3) return 1'b0;
            if (v == 2) drv++;
        end
        return drv <= 2;
    endfunction

    function automatic int first_bad(input logic [W-1:0] ws [N]);
        for (int i = 0; i < N; i++) if (!word_ok(ws[i])) return i;
        return -1;
    endfunction

    function automatic logic [N*W-1:0] expected_bus();
        logic [N*W-1:0] r = '0;
        for (int i = N - 1; i >= 0; i--) r = (r << W) | {{(N*W-W){1'b0}}, model_active[i]};
        return r;
    endfunction

    function automatic logic [W-1:0] gen_word();
        logic [W-1:0] w = '0;
        int v;
        for (int f = 3; f >= 0; f--) begin
            v = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            w = (w << 2) | W'(v);
        end
        w[8] = 1'($urandom);
        return w;
    endfunction

    // Runs one load transaction; abort_at >= N means no abort.
    task automatic applyStimulus(input logic [W-1:0] ws [N], input bit stall, input int abort_at);
        int i = 0;
        int budget = 0;
        int bad;
        bad = first_bad(ws);
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("ready_on_start", cfg_ready, 1);
        checkOutput("busy_on_start", busy, 1);
        checkOutput("error_cleared", error, 0);
        while (i < N && budget < 200) begin
            cfg_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_word  = cfg_valid ? ws[i] : W'($urandom);
            start     = stall ? 1'($urandom_range(0, 1)) : 1'b0;
            abort     = (abort_at == i) && cfg_valid;
            step();
            budget++;
            if (abort) begin
                abort = 1'b0; cfg_valid = 1'b0; start = 1'b0;
                checkOutput("abort_ready", cfg_ready, 0);
                checkOutput("abort_busy", busy, 0);
                step();
                checkOutput("abort_done", done, 0);
                checkOutput("abort_active", active_cfg, expected_bus());
                return;
            end
            if (cfg_valid) i++;
            if (i < N) checkOutput("ready_in_load", cfg_ready, 1);
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        if (i < N) begin
            checkOutput("load_timeout", i, N);
            return;
        end
        checkOutput("check_ready", cfg_ready, 0);
        checkOutput("check_busy", busy, 1);
        checkOutput("check_done", done, 0);
        step();
        checkOutput("e1_busy", busy, 0);
        checkOutput("e1_done", done, 0);
        checkOutput("e1_active", active_cfg, expected_bus());
        step();
        if (bad < 0) begin
            for (int k = 0; k < N; k++) model_active[k] = ws[k];
            checkOutput("commit_done", done, 1);
            checkOutput("commit_error", error, 0);
        end else begin
            checkOutput("err_flag", error, 1);
            checkOutput("err_idx", err_idx, bad);
            checkOutput("err_done", done, 0);
        end
        checkOutput("e2_active", active_cfg, expected_bus());
        step();
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [W-1:0] t2 [N];
        logic [W-1:0] t4 [N];
        logic [W-1:0] t5 [N];
        logic [W-1:0] rw [N];
        t2 = '{9'h184, 9'h054, 9'h0A0, 9'h1A0};
        t4 = '{9'h184, 9'h054, 9'h0C0, 9'h0AA};
        t5 = '{9'h011, 9'h108, 9'h022, 9'h180};
        for (int k = 0; k < N; k++) model_active[k] = '0;
        nrst = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
        #12;
        @(negedge clk) nrst = 1'b1;
        step();
        checkOutput("rst_active", active_cfg, 0);
        checkOutput("rst_ready", cfg_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_err_idx", err_idx, 0);

        // Words offered while idle must be refused.
        for (int k = 0; k < 3; k++) begin
            cfg_valid = 1'b1;
            cfg_word  = W'($urandom);
            step();
            checkOutput("idle_ready", cfg_ready, 0);
            checkOutput("idle_busy", busy, 0);
        end
        cfg_valid = 1'b0;

        applyStimulus(t2, 1'b0, N);
        checkOutput("t2_bus", active_cfg, {9'h1A0, 9'h0A0, 9'h054, 9'h184});
        applyStimulus(t2, 1'b1, N);
        applyStimulus(t4, 1'b0, N);
        checkOutput("t4_bus_kept", active_cfg, {9'h1A0, 9'h0A0, 9'h054, 9'h184});
        applyStimulus(t2, 1'b0, 2);
        applyStimulus(t5, 1'b0, N);

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < N; k++) rw[k] = gen_word();
            applyStimulus(rw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 9)));
        end

        // Asynchronous reset in the middle of a load.
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_valid = 1'b1;
        cfg_word = 9'h054;
        step();
        step();
        cfg_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) model_active[k] = '0;
        checkOutput("midrst_active", active_cfg, 0);
        checkOutput("midrst_ready", cfg_ready, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_error", error, 0);
        @(negedge clk) nrst = 1'b1;
        step();
        applyStimulus(t5, 1'b1, N);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
